// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if
// Bundles the two command channels and the response channel of the
// two-requester ALU front end. The master side is the pair of command
// producers plus the response consumer; the slave side is the arbiter.
interface alu_req_arbiter_if;

  // Requester 0 command channel
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;

  // Requester 1 command channel
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;

  // Response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic [2:0] rsp_cmp;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_cmp
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_cmp
  );

endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Two-requester front end for the 4-bit ALU (ADD / SUB / COMPARE / AND).
// One command is in flight at a time: IDLE accepts a command, EXEC evaluates
// it into the response register, RESP holds the response until the consumer
// takes it.
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration (the
// priority pointer flips to the loser on every accept). Without it,
// requester 0 always wins a tie and no priority pointer exists.
module alu_req_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_req_arbiter_if.slave     bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } op_t;

  // Captured command: everything EXEC needs plus the winner's id.
  typedef struct packed {
    op_t        op;
    logic [3:0] a;
    logic [3:0] b;
    logic       id;
  } cmd_t;

  // ALU outcome as presented on the response channel.
  typedef struct packed {
    logic [3:0] data;
    logic       carry;
    logic [2:0] cmp;
  } res_t;

  state_t state;
  cmd_t   cmd_q;
  cmd_t   win_cmd;
  res_t   alu_res;
  res_t   rsp_res_q;
  logic   rsp_valid_q;
  logic   rsp_id_q;
  logic   busy_q;
  logic   grant0;
  logic   grant1;
  logic   accept;
  logic [4:0] sum5;

`ifdef ALU_ARB_RR_EN
  // Requester that wins the next tie.
  logic   pri;
`endif

  // Grant selection: only in IDLE and never while reset is asserted, so the
  // readies read 0 during reset and may rise as soon as it is released.
  // NOTE: every signal assigned in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == ST_IDLE) begin
`ifdef ALU_ARB_RR_EN
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = ~pri;
        grant1 = pri;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
`else
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Winner's payload, steered into the command register on accept.
  always_comb begin
    if (grant1) begin
      win_cmd.op = op_t'(bus.req1_op);
      win_cmd.a  = bus.req1_a;
      win_cmd.b  = bus.req1_b;
      win_cmd.id = 1'b1;
    end else begin
      win_cmd.op = op_t'(bus.req0_op);
      win_cmd.a  = bus.req0_a;
      win_cmd.b  = bus.req0_b;
      win_cmd.id = 1'b0;
    end
  end

  // ALU evaluation from the command register; SUB is a + ~b + 1 so the
  // carry-out doubles as the "no borrow" flag (a >= b).
  always_comb begin
    alu_res = '0;
    sum5    = '0;
    case (cmd_q.op)
      OP_ADD: begin
        sum5          = {1'b0, cmd_q.a} + {1'b0, cmd_q.b};
        alu_res.data  = sum5[3:0];
        alu_res.carry = sum5[4];
      end
      OP_SUB: begin
        sum5          = {1'b0, cmd_q.a} + {1'b0, ~cmd_q.b} + 5'd1;
        alu_res.data  = sum5[3:0];
        alu_res.carry = sum5[4];
      end
      OP_CMP: begin
        alu_res.cmp = {cmd_q.a == cmd_q.b, cmd_q.a > cmd_q.b, cmd_q.a < cmd_q.b};
      end
      OP_AND: begin
        alu_res.data = cmd_q.a & cmd_q.b;
      end
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered command, response and busy.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge regardless of order.
  // NOTE: the command and response registers are reset along with the
  // control state because every response field must read 0 in reset and
  // an aborted command must not leak into a later response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      rsp_res_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
      pri         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q  <= win_cmd;
            busy_q <= 1'b1;
            state  <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
            pri    <= ~grant1;
`endif
          end
        end
        ST_EXEC: begin
          rsp_res_q   <= alu_res;
          rsp_id_q    <= cmd_q.id;
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_res_q.data;
  assign bus.rsp_carry = rsp_res_q.carry;
  assign bus.rsp_cmp   = rsp_res_q.cmp;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
// Table-driven single-command vectors, hand-written multi-cycle sequences
// (reset mid-response, tie arbitration, response backpressure) and a
// randomized run checked against a transaction-level scoreboard.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  alu_req_arbiter_if bus ();

  alu_req_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       carry;
    logic [2:0] cmp;
  } res_t;

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    res_t       exp;
  } vec_t;

  typedef struct {
    int   due;
    logic id;
    res_t res;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Arithmetic reference for the ALU function.
  function automatic res_t ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    res_t r;
    int   ia;
    int   ib;
    ia = int'(a);
    ib = int'(b);
    r.data  = 4'd0;
    r.carry = 1'b0;
    r.cmp   = 3'b000;
    case (op)
      2'b00: begin
        r.data  = 4'((ia + ib) % 16);
        r.carry = (ia + ib) > 15;
      end
      2'b01: begin
        r.data  = 4'((ia - ib + 16) % 16);
        r.carry = ia >= ib;
      end
      2'b10: r.cmp = (ia < ib) ? 3'b001 : ((ia > ib) ? 3'b010 : 3'b100);
      default: r.data = a & b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = 4'h0; bus.req0_b = 4'h0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Wait (bounded) until rsp_valid is seen; returns edges waited.
  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  // One command from one requester with rsp_ready held high.
  task automatic send(input vec_t v, input int idx);
    int   n;
    int   bcnt;
    logic rdy;
    drive_req(v.id, v.op, v.a, v.b);
    bus.rsp_ready = 1'b1;
    #1;
    n = 0;
    rdy = v.id ? bus.req1_ready : bus.req0_ready;
    while (rdy !== 1'b1 && n < 10) begin
      tick();
      n++;
      rdy = v.id ? bus.req1_ready : bus.req0_ready;
    end
    check($sformatf("vec%0d_accept", idx), rdy, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n    = 1;
    bcnt = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      if (busy) bcnt++;
      tick();
      n++;
    end
    if (busy) bcnt++;
    check($sformatf("vec%0d_latency", idx), n, 2);
    check($sformatf("vec%0d_id", idx), bus.rsp_id, v.id);
    check($sformatf("vec%0d_data", idx), bus.rsp_data, v.exp.data);
    check($sformatf("vec%0d_carry", idx), bus.rsp_carry, v.exp.carry);
    check($sformatf("vec%0d_cmp", idx), bus.rsp_cmp, v.exp.cmp);
    tick();
    if (busy) bcnt++;
    check($sformatf("vec%0d_busy_cycles", idx), bcnt, 2);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   n;
    int   got;
    logic ids   [4];
    logic [3:0] datas [4];
    exp_t q [$];
    logic pend [2];
    logic [1:0] p_op [2];
    logic [3:0] p_a  [2];
    logic [3:0] p_b  [2];
    int   cyc;
`ifdef ALU_ARB_RR_EN
    logic pri_m;
`endif

    //                 id    op     a     b     data  carry cmp
    vecs[0] = '{1'b0, 2'b00, 4'hF, 4'h1, '{4'h0, 1'b1, 3'b000}};
    vecs[1] = '{1'b1, 2'b01, 4'h3, 4'h5, '{4'hE, 1'b0, 3'b000}};
    vecs[2] = '{1'b1, 2'b01, 4'h5, 4'h3, '{4'h2, 1'b1, 3'b000}};
    vecs[3] = '{1'b0, 2'b10, 4'h7, 4'h7, '{4'h0, 1'b0, 3'b100}};
    vecs[4] = '{1'b0, 2'b10, 4'h2, 4'hA, '{4'h0, 1'b0, 3'b001}};
    vecs[5] = '{1'b1, 2'b10, 4'hC, 4'h4, '{4'h0, 1'b0, 3'b010}};
    vecs[6] = '{1'b1, 2'b11, 4'hC, 4'hA, '{4'h8, 1'b0, 3'b000}};
    vecs[7] = '{1'b0, 2'b00, 4'h9, 4'h8, '{4'h1, 1'b1, 3'b000}};

    // ---- reset state -------------------------------------------------
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);

    // ---- reset while holding a response (data 0x9) --------------------
    drive_req(1'b0, 2'b11, 4'hD, 4'hB);
    #1;
    n = 0;
    while (bus.req0_ready !== 1'b1 && n < 10) begin tick(); n++; end
    check("midrsp_accept", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    wait_rsp(n);
    check("midrsp_rsp_valid", bus.rsp_valid, 1);
    check("midrsp_rsp_data", bus.rsp_data, 4'h9);
    drive_req(1'b0, 2'b00, 4'h1, 4'h2);
    drive_req(1'b1, 2'b00, 4'h4, 4'h4);
    rst_n = 1'b0;
    #1;
    check("inrst_rsp_valid", bus.rsp_valid, 0);
    check("inrst_rsp_id", bus.rsp_id, 0);
    check("inrst_rsp_data", bus.rsp_data, 0);
    check("inrst_rsp_carry", bus.rsp_carry, 0);
    check("inrst_rsp_cmp", bus.rsp_cmp, 0);
    check("inrst_busy", busy, 0);
    check("inrst_req0_ready", bus.req0_ready, 0);
    check("inrst_req1_ready", bus.req1_ready, 0);
    tick();
    check("inrst_req0_ready_hold", bus.req0_ready, 0);
    rst_n = 1'b1;
    #1;
    check("postrst_req0_ready", bus.req0_ready, 1);
    check("postrst_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    wait_rsp(n);
    check("postrst_rsp_id", bus.rsp_id, 0);
    check("postrst_rsp_data", bus.rsp_data, 4'h3);
    tick();
    bus.rsp_ready = 1'b0;

    // ---- table-driven single commands --------------------------------
    for (int i = 0; i < 8; i++) send(vecs[i], i);

    // ---- both valid continuously, AND ops ----------------------------
    do_reset();
    drive_req(1'b0, 2'b11, 4'hC, 4'hA);
    drive_req(1'b1, 2'b11, 4'hF, 4'h3);
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        ids[got]   = bus.rsp_id;
        datas[got] = bus.rsp_data;
        got++;
      end
    end
    check("tie_rsp_count", got, 4);
    for (int i = 0; i < got; i++) begin
      logic exp_id;
`ifdef ALU_ARB_RR_EN
      exp_id = (i % 2) == 1;
`else
      exp_id = 1'b0;
`endif
      check($sformatf("tie%0d_id", i), ids[i], exp_id);
      check($sformatf("tie%0d_data", i), datas[i], exp_id ? 4'h3 : 4'h8);
    end
    set_idle();
    tick();
    tick();
    tick();

    // ---- response backpressure ---------------------------------------
    do_reset();
    drive_req(1'b0, 2'b00, 4'h6, 4'h7);
    #1;
    n = 0;
    while (bus.req0_ready !== 1'b1 && n < 10) begin tick(); n++; end
    check("bp_accept", bus.req0_ready, 1);
    tick();
    drive_req(1'b0, 2'b11, 4'hF, 4'h5);
    wait_rsp(n);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_rsp_valid", k), bus.rsp_valid, 1);
      check($sformatf("bp%0d_rsp_data", k), bus.rsp_data, 4'hD);
      check($sformatf("bp%0d_rsp_carry", k), bus.rsp_carry, 0);
      check($sformatf("bp%0d_rsp_id", k), bus.rsp_id, 0);
      check($sformatf("bp%0d_rsp_cmp", k), bus.rsp_cmp, 0);
      check($sformatf("bp%0d_req0_ready", k), bus.req0_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_rsp_valid", bus.rsp_valid, 1);
    tick();
    check("bp_next_req0_ready", bus.req0_ready, 1);
    check("bp_next_rsp_valid", bus.rsp_valid, 0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("bp_second_rsp_valid", bus.rsp_valid, 1);
    check("bp_second_rsp_data", bus.rsp_data, 4'h5);
    tick();
    set_idle();

    // ---- randomized run against a transaction scoreboard -------------
    do_reset();
    q.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    cyc = 0;
`ifdef ALU_ARB_RR_EN
    pri_m = 1'b0;
`endif
    for (int it = 0; it < 400; it++) begin
      logic in_flight;
      logic exp_rv;
      logic g0;
      logic g1;
      exp_t e;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(2) == 0) begin
          pend[r] = 1'b1;
          p_op[r] = 2'($urandom_range(3));
          p_a[r]  = 4'($urandom_range(15));
          p_b[r]  = 4'($urandom_range(15));
        end
      end
      bus.req0_valid = pend[0]; bus.req0_op = p_op[0]; bus.req0_a = p_a[0]; bus.req0_b = p_b[0];
      bus.req1_valid = pend[1]; bus.req1_op = p_op[1]; bus.req1_a = p_a[1]; bus.req1_b = p_b[1];
      bus.rsp_ready  = 1'($urandom_range(1));
      #1;
      in_flight = q.size() > 0;
      exp_rv = 1'b0;
      if (in_flight) exp_rv = cyc >= q[0].due;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!in_flight) begin
        if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
          g1 = pri_m;
`else
          g1 = 1'b0;
`endif
          g0 = ~g1;
        end else begin
          g0 = pend[0];
          g1 = pend[1];
        end
      end
      check("rand_req0_ready", bus.req0_ready, g0);
      check("rand_req1_ready", bus.req1_ready, g1);
      check("rand_busy", busy, in_flight);
      check("rand_rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rand_rsp_id", bus.rsp_id, q[0].id);
        check("rand_rsp_data", bus.rsp_data, q[0].res.data);
        check("rand_rsp_carry", bus.rsp_carry, q[0].res.carry);
        check("rand_rsp_cmp", bus.rsp_cmp, q[0].res.cmp);
        if (bus.rsp_ready) void'(q.pop_front());
      end
      if (g0 || g1) begin
        e.due = cyc + 2;
        e.id  = g1;
        e.res = g1 ? ref_alu(p_op[1], p_a[1], p_b[1]) : ref_alu(p_op[0], p_a[0], p_b[0]);
        q.push_back(e);
        if (g1) pend[1] = 1'b0; else pend[0] = 1'b0;
`ifdef ALU_ARB_RR_EN
        pri_m = ~g1;
`endif
      end
      cyc++;
      tick();
    end
    set_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester front end for the team's 4-bit ALU datapath (ADD / SUB / COMPARE / AND). Arbitrates between two command sources, latches the winning operands and opcode, and evaluates the ALU function in one execute cycle. Returns the registered result with the winner's ID over a valid/ready response channel. It sits between the two command producers and the shared ALU, so only one operation is in flight at a time.

## Interface
- No parameters; widths are fixed: 4-bit operands, 2-bit opcode.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised by the integrator.
- req0_valid / req1_valid  in  1  requester 0/1 has a command.
- req0_ready / req1_ready  out  1  command accepted this cycle when the matching valid is also high.
- req0_op / req1_op  in  2  opcode {s1,s0}: 00 ADD, 01 SUB, 10 COMPARE, 11 AND.
- req0_a, req0_b / req1_a, req1_b  in  4 each  unsigned operands.
- rsp_valid  out  1  response held stable.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the command.
- rsp_data  out  4  sum, difference, or AND result; 0 for COMPARE.
- rsp_carry  out  1  ADD/SUB carry-out; 0 for COMPARE and AND.
- rsp_cmp  out  3  [0] a<b, [1] a>b, [2] a==b for COMPARE; 000 otherwise.
- busy  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant exactly one ready, chosen among the asserted valids by the arbitration rule.
  - No ready is asserted when no valid is high.
  - Ready is combinational from valid and the priority pointer, and only asserted in IDLE.
  - On accept: capture op, a, b and id into the command register; go to EXEC.
- EXEC (one cycle):
  - Compute the result from the command register into the response register; go to RESP.
  - ADD: {carry,data} = a+b, 5-bit, carry = bit 4.
  - SUB: {carry,data} = a + ~b + 1. Carry = 1 means no borrow (a>=b). Data wraps modulo 16.
  - COMPARE: unsigned magnitude compare. Exactly one rsp_cmp bit is set.
  - AND: bitwise a&b.
- RESP:
  - rsp_valid = 1. All rsp_* fields stay stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE.
- Both readies are low in EXEC and RESP. New requests wait; requester valids must stay high with a stable payload until accepted.
- Arbitration: priority pointer `pri` (0 or 1).
  - Both valid: grant `pri`.
  - One valid: grant that requester.
  - On every accept, `pri` := ~granted id.
- Reset (any state, including mid-EXEC/RESP):
  - State IDLE, pri=0, any in-flight command and response discarded.
  - All outputs 0: rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_cmp, busy, req*_ready.
  - Readies may rise combinationally after reset is released.

## Timing
- Accept at edge N → EXEC during cycle N..N+1 → rsp_valid high after edge N+1 (2-edge latency).
- rsp_ready high at the first RESP cycle → back to IDLE after edge N+2. The next accept is possible at edge N+3. Peak throughput is 1 operation per 3 cycles.
- Response backpressure: every held RESP cycle adds one cycle; no command is lost or overwritten.
- rsp_ready while not in RESP is ignored.

## Configuration
- ALU_ARB_RR_EN defined: round-robin as described above (pri toggles on each accept).
- ALU_ARB_RR_EN undefined: fixed priority. Requester 0 always wins when both are valid; pri is not implemented. All other behaviour is identical.

## Test plan
- Reset mid-RESP, with rsp_valid=1 and rsp_data=0x9 → all outputs 0 during reset. After release, both valid → requester 0 granted.
- Req0 only, ADD a=0xF b=0x1, rsp_ready=1 → rsp_valid after 2 edges: data=0x0, carry=1, id=0, cmp=000. busy is high for 2 cycles.
- Req1 only, SUB a=0x3 b=0x5 → data=0xE, carry=0, id=1. Then SUB a=0x5 b=0x3 → data=0x2, carry=1.
- COMPARE a=0x7 b=0x7, then a=0x2 b=0xA, then a=0xC b=0x4 → rsp_cmp = 100, then 001, then 010; data=0, carry=0 each time.
- Both valid continuously, AND ops (req0 a=0xC b=0xA; req1 a=0xF b=0x3) → with RR_EN, ids alternate 0,1,0,1 with data 0x8,0x3,0x8,0x3. Without RR_EN, id is always 0.
- rsp_ready held low 5 cycles in RESP while req0_valid=1 → rsp fields stable, req0_ready=0 throughout. After rsp_ready, the next command is accepted 1 cycle later.
